// File: rtl/m55_sched.sv
// Buffer scheduler for the four m55 lane memories: tracks each buffer through
// load -> permute -> unload and issues selects, lane addresses and control pulses.
//
// state  | meaning
// S_FREE | empty, may be claimed by the loader
// S_LOAD | loader is writing lanes
// S_FULL | all 25 lanes written, waiting for the permutation engine
// S_PERM | owned by the permutation engine
// S_DONE | permuted, waiting for the first unload pop
// S_UNLD | being drained to the NoC output side
module m55_sched #(
   parameter int NBUF  = 4,
   parameter int LANES = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ld_push,
   input  logic       ld_first,
   output logic       ld_stop,
   output logic       ld_wr,
   output logic [1:0] ld_buf,
   output logic [2:0] ld_x,
   output logic [2:0] ld_y,
   output logic       pm_start,
   output logic [1:0] pm_buf,
   input  logic       pm_done,
   output logic       ul_valid,
   output logic [1:0] ul_buf,
   output logic [2:0] ul_x,
   output logic [2:0] ul_y,
   input  logic       ul_pop,
   output logic       ul_last,
   output logic       err
);

   typedef enum logic [2:0] {
      S_FREE, S_LOAD, S_FULL, S_PERM, S_DONE, S_UNLD
   } buf_state_e;

   localparam logic [4:0] LAST_LANE = 5'(LANES - 1);

   buf_state_e st_q [NBUF];
   buf_state_e st_n [NBUF];
   buf_state_e ld_cur, ul_cur;

   logic [1:0] ld_ptr_q, ld_ptr_n, pm_ptr_q, pm_ptr_n, ul_ptr_q, ul_ptr_n;
   logic [4:0] ld_lane_q, ld_lane_n, ul_lane_q, ul_lane_n, ld_lane;
   logic [2:0] ld_x_q, ld_x_n, ld_y_q, ld_y_n;
   logic [2:0] ul_x_q, ul_x_n, ul_y_q, ul_y_n;
   logic       ld_accept, perm_busy, perm_busy_n, start_n, err_n, pm_buf_sel;

   assign ld_cur    = st_q[ld_ptr_q];
   assign ul_cur    = st_q[ul_ptr_q];
   assign ld_stop   = !(ld_cur == S_FREE || ld_cur == S_LOAD);
   assign ld_accept = ld_push && !ld_stop && (ld_first || ld_cur == S_LOAD);
   assign ld_wr     = ld_accept;
   assign ld_buf    = ld_ptr_q;
   // ld_first always addresses lane 0, whatever the counter holds
   assign ld_lane   = ld_first ? 5'd0 : ld_lane_q;
   assign ld_x      = ld_first ? 3'd0 : ld_x_q;
   assign ld_y      = ld_first ? 3'd0 : ld_y_q;

   assign ul_valid  = (ul_cur == S_DONE) || (ul_cur == S_UNLD);
   assign ul_buf    = ul_ptr_q;
   assign ul_x      = ul_x_q;
   assign ul_y      = ul_y_q;
   assign ul_last   = ul_valid && (ul_lane_q == LAST_LANE);

   always_comb begin
      perm_busy = pm_start;
      for (int i = 0; i < NBUF; i++)
         if (st_q[i] == S_PERM) perm_busy = 1'b1;
   end

   always_comb begin
      st_n       = st_q;
      ld_ptr_n   = ld_ptr_q;
      pm_ptr_n   = pm_ptr_q;
      ul_ptr_n   = ul_ptr_q;
      ld_lane_n  = ld_lane_q;
      ld_x_n     = ld_x_q;
      ld_y_n     = ld_y_q;
      ul_lane_n  = ul_lane_q;
      ul_x_n     = ul_x_q;
      ul_y_n     = ul_y_q;
      err_n      = err;

      if (pm_start) st_n[pm_ptr_q] = S_PERM;

      if (ld_accept) begin
         if (ld_lane == LAST_LANE) begin
            st_n[ld_ptr_q] = S_FULL;
            ld_ptr_n       = ld_ptr_q + 2'd1;
            ld_lane_n      = 5'd0;
            ld_x_n         = 3'd0;
            ld_y_n         = 3'd0;
         end else begin
            st_n[ld_ptr_q] = S_LOAD;
            ld_lane_n      = ld_lane + 5'd1;
            ld_x_n         = (ld_x == 3'd4) ? 3'd0 : ld_x + 3'd1;
            ld_y_n         = (ld_x == 3'd4) ? ld_y + 3'd1 : ld_y;
         end
      end else if (ld_push && !ld_stop) begin
         err_n = 1'b1;
      end

      if (pm_done) begin
         if (perm_busy) begin
            st_n[pm_ptr_q] = S_DONE;
            pm_ptr_n       = pm_ptr_q + 2'd1;
         end else begin
            err_n = 1'b1;
         end
      end

      if (ul_pop) begin
         if (!ul_valid) begin
            err_n = 1'b1;
         end else if (ul_last) begin
            st_n[ul_ptr_q] = S_FREE;
            ul_ptr_n       = ul_ptr_q + 2'd1;
            ul_lane_n      = 5'd0;
            ul_x_n         = 3'd0;
            ul_y_n         = 3'd0;
         end else begin
            st_n[ul_ptr_q] = S_UNLD;
            ul_lane_n      = ul_lane_q + 5'd1;
            ul_x_n         = (ul_x_q == 3'd4) ? 3'd0 : ul_x_q + 3'd1;
            ul_y_n         = (ul_x_q == 3'd4) ? ul_y_q + 3'd1 : ul_y_q;
         end
      end

      // Start is decided on next state so it pulses right after the lane-24 write;
      // the buffer stays FULL during the pulse and becomes PERM at its end.
      perm_busy_n = 1'b0;
      for (int i = 0; i < NBUF; i++)
         if (st_n[i] == S_PERM) perm_busy_n = 1'b1;
      start_n    = (st_n[pm_ptr_n] == S_FULL) && !perm_busy_n;
      pm_buf_sel = start_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NBUF; i++) st_q[i] <= S_FREE;
         ld_ptr_q  <= 2'd0;
         pm_ptr_q  <= 2'd0;
         ul_ptr_q  <= 2'd0;
         ld_lane_q <= 5'd0;
         ld_x_q    <= 3'd0;
         ld_y_q    <= 3'd0;
         ul_lane_q <= 5'd0;
         ul_x_q    <= 3'd0;
         ul_y_q    <= 3'd0;
         pm_start  <= 1'b0;
         pm_buf    <= 2'd0;
         err       <= 1'b0;
      end else begin
         st_q      <= st_n;
         ld_ptr_q  <= ld_ptr_n;
         pm_ptr_q  <= pm_ptr_n;
         ul_ptr_q  <= ul_ptr_n;
         ld_lane_q <= ld_lane_n;
         ld_x_q    <= ld_x_n;
         ld_y_q    <= ld_y_n;
         ul_lane_q <= ul_lane_n;
         ul_x_q    <= ul_x_n;
         ul_y_q    <= ul_y_n;
         pm_start  <= start_n;
         if (pm_buf_sel) pm_buf <= pm_ptr_n;
         err       <= err_n;
      end
   end

endmodule
